// File: rtl/mario_key_ctrl.sv
// Turns the decoder's single-key press/release stream into WASD held flags,
// walk/crouch/facing levels and a frame-counted variable-height jump.
module mario_key_ctrl #(
  parameter int          MAX_JUMP_FRAMES = 16,
  parameter int          CNT_W           = 5,
  parameter logic [7:0]  ASCII_W         = 8'h57,
  parameter logic [7:0]  ASCII_A         = 8'h41,
  parameter logic [7:0]  ASCII_S         = 8'h53,
  parameter logic [7:0]  ASCII_D         = 8'h44
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       key_state,
  input  logic [7:0] key_ascii,
  input  logic       frame_tick,
  input  logic       on_ground,
  input  logic       enable,
  output logic [3:0] held,
  output logic       move_left,
  output logic       move_right,
  output logic       crouch,
  output logic       facing,
  output logic       jump_start,
  output logic       jump_hold
);

  typedef enum logic [1:0] {IDLE, RISE, LOCK} jump_state_t;

  localparam logic [3:0][7:0]   KEY_CODES = {ASCII_W, ASCII_A, ASCII_S, ASCII_D};
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_JUMP_FRAMES - 1);

  logic             r_ks;
  logic [7:0]       r_ka;
  logic [3:0]       r_held;
  logic             r_last_left;
  logic             r_move_left;
  logic             r_move_right;
  logic             r_crouch;
  logic             r_facing;
  jump_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;

  logic             w_press;
  logic             w_release;
  logic [3:0]       w_hit;
  logic [3:0]       w_held_next;
  logic             w_last_left_next;
  logic             w_crouch;
  logic             w_move_left;
  logic             w_move_right;
  logic             w_facing_next;
  jump_state_t      w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_first_next;

  // A new code while the key stays down counts as a press; a repeat does not.
  assign w_press   = key_state & (key_ascii != 8'h00) & (~r_ks | (key_ascii != r_ka));
  assign w_release = r_ks & ~key_state;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key_hit
    assign w_hit[gi] = w_press & (key_ascii == KEY_CODES[gi]);
  end

  always_comb begin
    w_held_next      = r_held;
    w_last_left_next = r_last_left;
    if (w_release) begin
      // The decoder does not say which key went up, so all flags drop.
      w_held_next = 4'b0000;
    end else begin
      w_held_next = r_held | w_hit;
      if (w_hit[2]) w_last_left_next = 1'b1;
      else if (w_hit[0]) w_last_left_next = 1'b0;
    end
  end

  assign w_crouch     = r_held[1] & on_ground & enable;
  assign w_move_left  = enable & ~w_crouch & r_held[2] & (~r_held[0] | r_last_left);
  assign w_move_right = enable & ~w_crouch & r_held[0] & (~r_held[2] | ~r_last_left);

  always_comb begin
    w_facing_next = r_facing;
    if (w_move_left & ~r_move_left) w_facing_next = 1'b1;
    else if (w_move_right & ~r_move_right) w_facing_next = 1'b0;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_first_next = 1'b0;
    if (!enable) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_held[3] & on_ground & ~w_crouch) begin
            w_state_next = RISE;
            w_cnt_next   = '0;
            w_first_next = 1'b1;
          end
        end
        RISE: begin
          // Letting go of W ends the rise even if a frame tick lands together.
          if (!r_held[3]) begin
            w_state_next = LOCK;
          end else if (frame_tick) begin
            if (r_cnt == CNT_MAX) w_state_next = LOCK;
            else w_cnt_next = r_cnt + 1'b1;
          end
        end
        LOCK: begin
          if (!r_held[3]) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_ks         <= 1'b0;
      r_ka         <= 8'h00;
      r_held       <= 4'b0000;
      r_last_left  <= 1'b0;
      r_move_left  <= 1'b0;
      r_move_right <= 1'b0;
      r_crouch     <= 1'b0;
      r_facing     <= 1'b0;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_first      <= 1'b0;
    end else begin
      r_ks         <= key_state;
      r_ka         <= key_ascii;
      r_held       <= w_held_next;
      r_last_left  <= w_last_left_next;
      r_move_left  <= w_move_left;
      r_move_right <= w_move_right;
      r_crouch     <= w_crouch;
      r_facing     <= w_facing_next;
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_first      <= w_first_next;
    end
  end

  assign held       = r_held;
  assign move_left  = r_move_left;
  assign move_right = r_move_right;
  assign crouch     = r_crouch;
  assign facing     = r_facing;
  assign jump_hold  = enable & (r_state == RISE);
  assign jump_start = jump_hold & r_first;

endmodule

// File: doc/mario_key_ctrl.md
Name: mario_key_ctrl

Overview:
- Downstream consumer of the PS/2 ASCII decoder's key_state / key_ascii pair.
- Converts the single-key press/release stream into per-key held flags and registered game-action levels: move left/right, crouch, facing.
- Runs a jump state machine that produces a one-cycle jump start and a frame-counted variable-height jump hold for the Mario physics block.

Parameters:
MAX_JUMP_FRAMES, 16, maximum frame_tick count that jump_hold may stay high per jump
CNT_W, 5, width of the jump frame counter; must hold MAX_JUMP_FRAMES-1
ASCII_W, 8'h57, code mapped to jump
ASCII_A, 8'h41, code mapped to left
ASCII_S, 8'h53, code mapped to crouch
ASCII_D, 8'h44, code mapped to right

Ports:
clk_in  input  1  system clock
rst  input  1  asynchronous, active-low reset
key_state  input  1  1 while the decoder reports a key down
key_ascii  input  8  decoder ASCII code; 0 = none
frame_tick  input  1  one-clk_in pulse per game frame
on_ground  input  1  Mario standing on ground (from physics)
enable  input  1  1 = gameplay active; 0 = outputs masked
held  output  4  {W,A,S,D} held flags, bit3 = W
move_left  output  1  walk left level
move_right  output  1  walk right level
crouch  output  1  crouch level
facing  output  1  0 = right, 1 = left
jump_start  output  1  one-cycle pulse at jump launch
jump_hold  output  1  jump rising phase active

Behaviour:
- Reset, asynchronous on rst low:
  - held = 0; move_left, move_right, crouch, jump_start, jump_hold = 0; facing = 0.
  - FSM = IDLE; frame counter = 0; last_dir = right.
  - Input delay registers: ks_r = 0, ka_r = 0.
- Input delay: ks_r and ka_r register key_state and key_ascii every cycle.
- Events, evaluated on current inputs against the delayed registers:
  - press = key_state & key_ascii != 0 & (!ks_r | key_ascii != ka_r).
  - release = ks_r & !key_state.
  - press and release are mutually exclusive by construction.
- Held flags, registered, visible 1 cycle after the event:
  - press of a mapped code sets its flag; other flags are unchanged.
  - press of an unmapped code: no change.
  - release clears all four flags. The decoder does not identify the released key; typematic repeat re-sets any key still down.
  - A repeat of the same code while key_state stays 1 is not a press.
- last_dir: A press sets left; D press sets right.
- Action levels, registered, 1 cycle after held changes:
  - crouch = held.S & on_ground & enable.
  - move_left = enable & !crouch & held.A & (!held.D | last_dir == left).
  - move_right = enable & !crouch & held.D & (!held.A | last_dir == right).
  - facing updates to 1 when move_left rises and to 0 when move_right rises; otherwise it holds its value.
- Jump FSM: IDLE, RISE, LOCK. The counter is CNT_W bits.
  - IDLE → RISE when held.W & on_ground & !crouch & enable; counter clears to 0. jump_start = 1 for exactly the first RISE cycle.
  - RISE: jump_hold = 1.
    - On frame_tick: if counter == MAX_JUMP_FRAMES-1, go to LOCK; else counter increments. A tick in the first RISE cycle counts.
    - If !held.W, go to LOCK immediately; this takes priority over a tick in the same cycle.
  - LOCK: jump_hold = 0. Go to IDLE when !held.W. This blocks auto-repeat re-jumps while W stays held.
  - enable = 0 in any state: next state IDLE, jump_start and jump_hold forced 0, counter cleared. Held flags keep tracking.
- Counter never wraps; its maximum value is MAX_JUMP_FRAMES-1.
- Reset mid-jump returns to IDLE with all outputs 0 immediately (asynchronous).

Test Plan:
- Reset, then key_state=1 / key_ascii=8'h44 for 10 cycles → held=4'b0001 and move_right=1 two cycles after the press; facing stays 0.
- D held, then key_ascii changes to 8'h41 with key_state still 1 → held=4'b0101; move_left=1, move_right=0, facing=1.
- on_ground=1, W pressed and held through 20 frame_ticks with MAX_JUMP_FRAMES=16 → jump_start high exactly one cycle; jump_hold high until the 16th tick, then LOCK; no second jump_start until W is released and pressed again.
- W pressed, released after 3 frame_ticks → jump_hold drops the cycle after held.W clears; FSM LOCK → IDLE.
- S held with on_ground=1 and A also pressed → crouch=1, move_left=0; W press produces no jump_start.
- enable=0 during RISE → jump_hold=0 next cycle; then assert rst low mid-jump → all outputs 0 asynchronously; held=0.
